// File: rtl/controle_andar_pkg.sv
// Shared types and width helpers for the elevator cabin motion controller.
package controle_andar_pkg;

  typedef enum logic [1:0] {
    PARADO,
    SUBINDO,
    DESCENDO,
    PORTA_ABERTA
  } estado_t;

  typedef enum logic {
    UP,
    DOWN
  } direcao_t;

  function automatic int largura(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/busca_pedidos.sv
// Reports whether any request lies above, below or exactly at a given floor.
module busca_pedidos
  import controle_andar_pkg::*;
#(
  parameter  int NUM_ANDARES = 4,
  localparam int AW          = largura(NUM_ANDARES)
) (
  input  logic [NUM_ANDARES-1:0] pendentes,
  input  logic [AW-1:0]          andar_atual,
  output logic                   tem_acima,
  output logic                   tem_abaixo,
  output logic                   tem_aqui
);

  logic [NUM_ANDARES-1:0] mask_acima, mask_abaixo, mask_aqui;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mask_acima  = '0;
    mask_abaixo = '0;
    mask_aqui   = '0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      mask_acima[i]  = (i > int'(andar_atual));
      mask_abaixo[i] = (i < int'(andar_atual));
      mask_aqui[i]   = (i == int'(andar_atual));
    end
  end

  assign tem_acima  = |(pendentes & mask_acima);
  assign tem_abaixo = |(pendentes & mask_abaixo);
  assign tem_aqui   = |(pendentes & mask_aqui);

endmodule

// File: rtl/controle_andar.sv
// Cabin motion controller: latches floor calls and serves them with SCAN scheduling,
// timing floor-to-floor travel and door dwell.
module controle_andar
  import controle_andar_pkg::*;
#(
  parameter  int NUM_ANDARES = 4,
  parameter  int TEMPO_ANDAR = 8,
  parameter  int TEMPO_PORTA = 4,
  localparam int AW          = largura(NUM_ANDARES),
  localparam int TW          = largura(maximo(TEMPO_ANDAR, TEMPO_PORTA) + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ANDARES-1:0] pedido,
  output logic                   subindo,
  output logic                   descendo,
  output logic [AW-1:0]          andar_atual,
  output logic                   porta_aberta,
  output logic [NUM_ANDARES-1:0] pendentes
);

  estado_t                estado, estado_prox;
  direcao_t               ultima_dir, dir_prox;
  logic [TW-1:0]          timer, timer_prox;
  logic [AW-1:0]          andar_prox, andar_vizinho;
  logic [NUM_ANDARES-1:0] visiveis, servido;
  logic                   tem_acima, tem_abaixo, tem_aqui;
  logic                   viz_acima, viz_abaixo, viz_aqui;

  // Same-cycle calls count toward every decision, not only latched ones.
  assign visiveis      = pendentes | pedido;
  assign andar_vizinho = (estado == DESCENDO) ? andar_atual - AW'(1) : andar_atual + AW'(1);

  busca_pedidos #(.NUM_ANDARES(NUM_ANDARES)) u_busca_aqui (
    .pendentes  (visiveis),
    .andar_atual(andar_atual),
    .tem_acima  (tem_acima),
    .tem_abaixo (tem_abaixo),
    .tem_aqui   (tem_aqui)
  );

  // Looks at the floor the cabin is about to arrive at.
  busca_pedidos #(.NUM_ANDARES(NUM_ANDARES)) u_busca_vizinho (
    .pendentes  (visiveis),
    .andar_atual(andar_vizinho),
    .tem_acima  (viz_acima),
    .tem_abaixo (viz_abaixo),
    .tem_aqui   (viz_aqui)
  );

  always_comb begin
    estado_prox = estado;
    andar_prox  = andar_atual;
    timer_prox  = timer;
    dir_prox    = ultima_dir;
    servido     = '0;
    unique case (estado)
      PARADO: begin
        if (tem_aqui)                                          estado_prox = PORTA_ABERTA;
        else if (tem_acima && (ultima_dir == UP || !tem_abaixo)) estado_prox = SUBINDO;
        else if (tem_abaixo)                                   estado_prox = DESCENDO;
      end
      SUBINDO, DESCENDO: begin
        if (timer == TW'(TEMPO_ANDAR - 1)) begin
          andar_prox = andar_vizinho;
          timer_prox = '0;
          dir_prox   = (estado == SUBINDO) ? UP : DOWN;
          if (viz_aqui)                                         estado_prox = PORTA_ABERTA;
          else if ((estado == SUBINDO) ? viz_acima : viz_abaixo) estado_prox = estado;
          else                                                  estado_prox = PARADO;
        end else begin
          timer_prox = timer + TW'(1);
        end
      end
      PORTA_ABERTA: begin
        if (pedido[andar_atual]) begin
          timer_prox = '0;
        end else if (timer == TW'(TEMPO_PORTA - 1)) begin
          estado_prox = PARADO;
          timer_prox  = '0;
        end else begin
          timer_prox = timer + TW'(1);
        end
      end
    endcase
    // Clear the floor where the door is (or is about to be) open, so it never stays pending.
    if (estado == PORTA_ABERTA || estado_prox == PORTA_ABERTA) servido[andar_prox] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= PARADO;
      andar_atual  <= '0;
      pendentes    <= '0;
      timer        <= '0;
      ultima_dir   <= UP;
      subindo      <= 1'b0;
      descendo     <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      estado       <= estado_prox;
      andar_atual  <= andar_prox;
      pendentes    <= visiveis & ~servido;
      timer        <= timer_prox;
      ultima_dir   <= dir_prox;
      subindo      <= (estado_prox == SUBINDO);
      descendo     <= (estado_prox == DESCENDO);
      porta_aberta <= (estado_prox == PORTA_ABERTA);
    end
  end

  a_direcao_exclusiva: assert property (@(posedge clk) disable iff (!rst_n) !(subindo && descendo));

endmodule
